// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer for the 5-stage MIPS pipeline.
// Owns HI/LO. It accepts mult/multu/div/divu/mthi/mtlo from the E stage.
// A busy counter models the fixed multiply and divide latency. The block
// supplies the HI/LO read data and the D-stage stall request.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     E-stage MDU operation valid this cycle
//   mdOp      000 none, 001 mult, 010 multu, 011 div, 100 divu,
//             101 mthi, 110 mtlo, 111 reserved (no-op)
//   A, B      forwarded rs / rt operands
//   hiloSel   read select for hiloData: 1 = HI, 0 = LO
//   D_useMd   instruction in D uses the MDU
//   busy      multi-cycle operation in progress (registered)
//   stallReq  D-stage stall request (combinational)
//   HI, LO    architectural HI/LO registers
//   hiloData  hiloSel ? HI : LO (combinational)
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hiloSel,
  input  logic        D_useMd,
  output logic        busy,
  output logic        stallReq,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] hiloData
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pendHi;
  logic [31:0]      pendLo;
  logic             pendWrite;

  logic        isMdOp;
  logic        isMul;
  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;
  logic        negA;
  logic        negB;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] divisor;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] resHi;
  logic [31:0] resLo;
  logic        resWrite;

  assign isMdOp = (mdOp == OP_MULT) || (mdOp == OP_MULTU) ||
                  (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
  assign isMul  = (mdOp == OP_MULT) || (mdOp == OP_MULTU);

  // Result datapath. Division works on magnitudes and then fixes the signs.
  // As a result, 0x80000000 / -1 yields LO = 0x80000000 and HI = 0 with no
  // special case.
  always_comb begin
    mulA     = (mdOp == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
    mulB     = (mdOp == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
    product  = mulA * mulB;
    negA     = (mdOp == OP_DIV) && A[31];
    negB     = (mdOp == OP_DIV) && B[31];
    absA     = negA ? (~A + 32'd1) : A;
    absB     = negB ? (~B + 32'd1) : B;
    // A zero divisor is replaced so the datapath stays defined.
    // The result is then suppressed through resWrite.
    divisor  = (B == 32'd0) ? 32'd1 : absB;
    quot     = absA / divisor;
    rem      = absA % divisor;
    resHi    = '0;
    resLo    = '0;
    resWrite = 1'b0;
    if (isMul) begin
      resHi    = product[63:32];
      resLo    = product[31:0];
      resWrite = 1'b1;
    end else begin
      resLo    = (negA ^ negB) ? (~quot + 32'd1) : quot;
      resHi    = negA ? (~rem + 32'd1) : rem;
      resWrite = (B != 32'd0);
    end
  end

  // Sequencer: launch in IDLE, count down in RUN, commit on the 1 -> 0 edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (isMdOp) begin
              pendHi    <= resHi;
              pendLo    <= resLo;
              pendWrite <= resWrite;
              counter   <= isMul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy      <= 1'b1;
              state     <= RUN;
            end else if (mdOp == OP_MTHI) begin
              HI <= A;
            end else if (mdOp == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          // Any start while running is dropped.
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (pendWrite) begin
              HI <= pendHi;
              LO <= pendLo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The stall also covers the launch cycle, before busy has risen.
  assign stallReq = D_useMd & (busy | (start & isMdOp));
  assign hiloData = hiloSel ? HI : LO;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed scoreboard bench for md_ctrl.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        hiloSel;
  logic        D_useMd;
  logic        busy;
  logic        stallReq;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] hiloData;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] expQ[$];
  logic [31:0] curHi = 32'd0;
  logic [31:0] curLo = 32'd0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp), .A(A), .B(B),
    .hiloSel(hiloSel), .D_useMd(D_useMd), .busy(busy), .stallReq(stallReq),
    .HI(HI), .LO(LO), .hiloData(hiloData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch a multi-cycle op and count its busy cycles. HI/LO must hold the
  // old values while busy and take the scoreboard value afterwards.
  // intrudeAt >= 0 drives a mtlo 0xAAAA in that busy cycle.
  task automatic doOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int n, input logic [31:0] eh,
                      input logic [31:0] el, input int intrudeAt);
    int cnt;
    logic [63:0] e;
    expQ.push_back({eh, el});
    @(negedge clk);
    start = 1'b1; mdOp = op; A = a; B = b;
    #1 chk({tag, "_stall_launch"}, 64'(stallReq), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'b000;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      start = 1'b0; mdOp = 3'b000;
      chk({tag, "_stall_busy"}, 64'(stallReq), 64'd1);
      chk({tag, "_hilo_hold"}, {HI, LO}, {curHi, curLo});
      if (cnt == intrudeAt) begin
        start = 1'b1; mdOp = 3'b110; A = 32'h0000AAAA;
      end
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0; mdOp = 3'b000;
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    chk({tag, "_stall_drop"}, 64'(stallReq), 64'd0);
    e = expQ.pop_front();
    chk({tag, "_hilo"}, {HI, LO}, e);
    curHi = e[63:32];
    curLo = e[31:0];
  endtask

  // mthi/mtlo: single-cycle write, no busy, no stall.
  task automatic doMt(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; mdOp = op; A = a;
    #1 chk({tag, "_stall"}, 64'(stallReq), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'b000;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    if (op == 3'b101) curHi = a; else curLo = a;
    chk({tag, "_hilo"}, {HI, LO}, {curHi, curLo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdOp = 3'b000; A = '0; B = '0;
    hiloSel = 1'b0; D_useMd = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_hilodata", 64'(hiloData), 64'd0);

    // stallReq needs D_useMd
    @(negedge clk);
    D_useMd = 1'b0; start = 1'b1; mdOp = 3'b001;
    #1 chk("stall_no_duse", 64'(stallReq), 64'd0);
    start = 1'b0; mdOp = 3'b000; D_useMd = 1'b1;

    doOp("mult",  3'b001, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB, -1);
    doOp("multu", 3'b010, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, -1);
    doOp("div",   3'b011, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
    doOp("divovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, -1);
    doOp("divu",  3'b100, 32'd100, 32'd7, 10, 32'd2, 32'd14, -1);

    doMt("mthi", 3'b101, 32'h00001234);
    doMt("mtlo", 3'b110, 32'h00005678);
    hiloSel = 1'b1;
    #1 chk("hilodata_hi", 64'(hiloData), 64'h1234);
    hiloSel = 1'b0;
    #1 chk("hilodata_lo", 64'(hiloData), 64'h5678);

    doOp("divu0", 3'b100, 32'd99, 32'd0, 10, 32'h00001234, 32'h00005678, -1);
    doOp("div0",  3'b011, 32'hFFFFFFF0, 32'd0, 10, 32'h00001234, 32'h00005678, -1);

    // mtlo arriving mid-busy must be dropped
    doOp("intrude", 3'b001, 32'd3, 32'd4, 5, 32'd0, 32'd12, 2);

    // reset in the 4th busy cycle of a div discards it
    @(negedge clk);
    start = 1'b1; mdOp = 3'b011; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'b000;
    repeat (3) @(posedge clk);
    #1 chk("rstmid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_hilo", {HI, LO}, 64'd0);
    curHi = 32'd0; curLo = 32'd0;
    repeat (12) @(posedge clk);
    #1 chk("rstmid_no_commit", {HI, LO}, 64'd0);
    chk("rstmid_still_idle", 64'(busy), 64'd0);

    // back-to-back: div launched in the first idle cycle after mult
    doOp("b2b_mult", 3'b001, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, -1);
    doOp("b2b_div",  3'b011, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer for the 5-stage MIPS pipeline.
- Owns the HI/LO registers.
- Accepts operations from the E stage and models the fixed multi-cycle latency of multiply and divide with a busy counter.
- Supplies HI/LO read data (the source of W_hiloData) and produces the D-stage stall request for MDU-dependent instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage MDU operation valid this cycle
- mdOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (no-op)
- A  input  32  operand rs (forwarded)
- B  input  32  operand rt (forwarded)
- hiloSel  input  1  read select: 1 = HI, 0 = LO (mfhi/mflo)
- D_useMd  input  1  instruction in D is any mult/div/mthi/mtlo/mfhi/mflo
- busy  output  1  multi-cycle operation in progress
- stallReq  output  1  = D_useMd & (busy | (start & mdOp in {001..100}))
- HI  output  32  HI register
- LO  output  32  LO register
- hiloData  output  32  hiloSel ? HI : LO, combinational

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: state = IDLE, counter = 0, busy = 0, HI = 0, LO = 0.
  - Reset wins over every other event, including an operation in flight; a pending result is discarded.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1.
- IDLE with start = 1 and mdOp in {mult, multu, div, divu}:
  - The result is computed from A/B sampled at this edge and held in internal pending registers.
  - Counter loads MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter goes 1 -> 0, HI/LO take the pending values and the state returns to IDLE.
- Timing: with start at edge t, busy is high for exactly N cycles after t. HI/LO show the new values in the first cycle busy is low. A new start is accepted at that same edge.
- mthi/mtlo in IDLE: HI (respectively LO) <= A at that edge; busy stays 0.
- Any start while busy = 1 (any mdOp) is ignored. The pipeline guarantees this does not happen; the block must still tolerate it.
- mdOp = 000 or 111 with start = 1: no effect.
- Arithmetic rules:
  - mult: signed 32x32 -> 64, {HI,LO} = product.
  - multu: unsigned 32x32 -> 64.
  - div/divu: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend for div.
  - div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0 (div or divu): the operation still runs the full DIV_CYCLES with busy high; HI/LO are left unchanged at completion.
- hiloData and HI/LO outputs reflect register state only, with no bypass of the pending result while busy.
  - stallReq holds mfhi/mflo in D until completion.
- stallReq is combinational.
  - It is asserted in the start cycle so the next MDU instruction cannot enter E while the operation launches.

Test Plan:
- reset, then start mult A=0xFFFFFFFD B=7 -> busy=1 for exactly 5 cycles; afterward HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=0xFFFFFFFF B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
- div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with B=0 after HI=0x1234, LO=0x5678 -> busy 10 cycles; HI/LO unchanged.
- Busy-window checks, D_useMd=1 throughout:
  - stallReq=1 from the start cycle through the last busy cycle, then drops.
  - start with mtlo A=0xAAAA mid-busy -> ignored; LO holds the pending mult result.
- reset asserted at the 4th busy cycle of div -> next cycle busy=0, HI=LO=0; pending result never appears.
- Back-to-back: mult completes; start div in the first non-busy cycle -> accepted; busy stays high the next 10 cycles.
